// File: rtl/pipeline.sv
// pipeline: fixed-latency instruction/address pipeline.
// An instruction word and its address move in lockstep through DEPTH
// register stages, which model the IF/ID -> ID/EX -> EX/MEM -> MEM/WB
// inter-stage registers. The pipeline advances on every rising clock edge.
// There are no stall or flush inputs.
// DEPTH must lie in 1..16. The latency is DEPTH rising edges, counting the
// edge that samples the pair.
// Optional build macro PIPELINE_NOP_SQUASH_EN: when a NOP (instruction
// word 0) enters stage 0, its address is forced to 0. NOP bubbles then
// always emerge as ins=0, dir=0.
module pipeline #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] insi,
    input  logic [WIDTH-1:0] diri,
    output logic [WIDTH-1:0] ins,
    output logic [WIDTH-1:0] dir
);

    // Two parallel shift chains. Index 0 is the fetch side and DEPTH-1 is
    // the retire side. The instruction bits and address bits never mix.
    logic [WIDTH-1:0] ins_q [DEPTH];
    logic [WIDTH-1:0] dir_q [DEPTH];

    // Next values for stage 0. Only the address path can differ between
    // the two builds.
    logic [WIDTH-1:0] ins_d;
    logic [WIDTH-1:0] dir_d;

    // Form the stage-0 capture values from the fetch inputs.
    always_comb begin
        ins_d = insi;
`ifdef PIPELINE_NOP_SQUASH_EN
        dir_d = (insi == '0) ? '0 : diri;
`else
        dir_d = diri;
`endif
    end

    // Shift both chains one stage per clock. Reset clears every stage at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every stage is cleared, not only the last one. This is
            // a shift chain and not a RAM. Leaving the inner stages
            // unreset would let stale pairs surface after reset.
            for (int k = 0; k < DEPTH; k++) begin
                ins_q[k] <= '0;
                dir_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage read its
            // neighbour's old value. With blocking assignments the chain
            // would collapse into a single stage.
            ins_q[0] <= ins_d;
            dir_q[0] <= dir_d;
            for (int k = 1; k < DEPTH; k++) begin
                ins_q[k] <= ins_q[k-1];
                dir_q[k] <= dir_q[k-1];
            end
        end
    end

    // The outputs are taken straight from the last stage's flops.
    assign ins = ins_q[DEPTH-1];
    assign dir = dir_q[DEPTH-1];

endmodule

// File: tb/tb_pipeline.sv
// tb_pipeline: directed, table-driven bench for pipeline.
// It drives a DEPTH=4 instance and a DEPTH=1 instance from the same inputs.
// Inputs change on falling edges. Outputs are sampled 1 time unit after
// each rising edge.
module tb_pipeline;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] insi = '0;
    logic [W-1:0] diri = '0;
    logic [W-1:0] ins4, dir4, ins1, dir1;

    int tests = 0;
    int fails = 0;

    pipeline #(.WIDTH(W), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .insi(insi), .diri(diri), .ins(ins4), .dir(dir4)
    );

    pipeline #(.WIDTH(W), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .insi(insi), .diri(diri), .ins(ins1), .dir(dir1)
    );

    always #5 clk = ~clk;

    // Expected address of a NOP that entered with a nonzero address.
`ifdef PIPELINE_NOP_SQUASH_EN
    localparam logic [W-1:0] NOP_DIR = 32'h0000_0000;
`else
    localparam logic [W-1:0] NOP_DIR = 32'hFFFF_0000;
`endif

    typedef struct {
        logic [W-1:0] insi;
        logic [W-1:0] diri;
        logic [W-1:0] exp_ins;   // DEPTH=4 output after this edge
        logic [W-1:0] exp_dir;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive rst/inputs on a falling edge, then move to just after the next rising edge.
    task automatic apply(input logic r, input logic [W-1:0] i, input logic [W-1:0] d);
        @(negedge clk);
        rst  = r;
        insi = i;
        diri = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Streaming table. A pair sampled at edge N appears after edge N+3.
        vecs[0] = '{32'h0011_0011, 32'h0000_FFFF, 32'h0, 32'h0};
        vecs[1] = '{32'h0001_0001, 32'hFFFF_0000, 32'h0, 32'h0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0, 32'h0};
        vecs[3] = '{32'h0010_0010, 32'h0000_FFFF, 32'h0011_0011, 32'h0000_FFFF};
        vecs[4] = '{32'h1000_1000, 32'hFFFF_0000, 32'h0001_0001, 32'hFFFF_0000};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 32'h0010_0010, 32'h0000_FFFF};
        vecs[7] = '{32'h0000_0000, 32'h0000_0000, 32'h1000_1000, 32'hFFFF_0000};
        vecs[8] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

        // Reset held for 3 edges with nonzero inputs.
        #1;
        check("reset_t0_ins", ins4, 32'h0);
        check("reset_t0_dir", dir4, 32'h0);
        for (int e = 0; e < 3; e++) begin
            apply(1'b1, 32'h0011_0011, 32'h0000_FFFF);
            check($sformatf("reset_hold%0d_ins", e), ins4, 32'h0);
            check($sformatf("reset_hold%0d_dir", e), dir4, 32'h0);
            check($sformatf("reset_hold%0d_ins_d1", e), ins1, 32'h0);
            check($sformatf("reset_hold%0d_dir_d1", e), dir1, 32'h0);
        end

        // Streaming. The first vector is sampled on the first edge after reset.
        for (int v = 0; v < 9; v++) begin
            apply(1'b0, vecs[v].insi, vecs[v].diri);
            check($sformatf("stream%0d_ins", v), ins4, vecs[v].exp_ins);
            check($sformatf("stream%0d_dir", v), dir4, vecs[v].exp_dir);
            check($sformatf("stream%0d_ins_d1", v), ins1, vecs[v].insi);
            check($sformatf("stream%0d_dir_d1", v), dir1, vecs[v].diri);
        end

        // Latency: a single pulse appears only after the 4th edge.
        for (int e = 1; e <= 6; e++) begin
            if (e == 1) apply(1'b0, 32'h0011_0011, 32'h0000_FFFF);
            else        apply(1'b0, 32'h0, 32'h0);
            check($sformatf("latency_e%0d_ins", e), ins4, (e == 4) ? 32'h0011_0011 : 32'h0);
            check($sformatf("latency_e%0d_dir", e), dir4, (e == 4) ? 32'h0000_FFFF : 32'h0);
        end

        // Mid-stream reset. Four pairs are fed in. After the 4th edge the
        // first pair is visible and the other three are still in flight.
        apply(1'b0, 32'h0011_0011, 32'h0000_FFFF);
        apply(1'b0, 32'h0001_0001, 32'hFFFF_0000);
        apply(1'b0, 32'h0010_0010, 32'h0000_FFFF);
        apply(1'b0, 32'h1000_1000, 32'hFFFF_0000);
        check("midrst_pre_ins", ins4, 32'h0011_0011);
        check("midrst_pre_dir", dir4, 32'h0000_FFFF);
        check("midrst_pre_ins_d1", ins1, 32'h1000_1000);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_async_ins", ins4, 32'h0);
        check("midrst_async_dir", dir4, 32'h0);
        check("midrst_async_ins_d1", ins1, 32'h0);
        check("midrst_async_dir_d1", dir1, 32'h0);
        // rst is released on the next falling edge. New data then needs the full latency.
        for (int e = 1; e <= 5; e++) begin
            if (e == 1) apply(1'b0, 32'h0100_0100, 32'hFFFF_0000);
            else        apply(1'b0, 32'h0, 32'h0);
            check($sformatf("midrst_e%0d_ins", e), ins4, (e == 4) ? 32'h0100_0100 : 32'h0);
            check($sformatf("midrst_e%0d_dir", e), dir4, (e == 4) ? 32'hFFFF_0000 : 32'h0);
            if (e == 1) begin
                check("depth1_ins", ins1, 32'h0100_0100);
                check("depth1_dir", dir1, 32'hFFFF_0000);
            end
        end

        // NOP with a nonzero address.
        for (int e = 1; e <= 4; e++) begin
            if (e == 1) apply(1'b0, 32'h0, 32'hFFFF_0000);
            else        apply(1'b0, 32'h0, 32'h0);
            if (e == 1) check("nop_dir_d1", dir1, NOP_DIR);
            check($sformatf("nop_e%0d_ins", e), ins4, 32'h0);
            check($sformatf("nop_e%0d_dir", e), dir4, (e == 4) ? NOP_DIR : 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
